// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus.
//   master (fetch side): drives req/addr, receives ready/rvalid/rdata.
//   slave (memory side): receives req/addr, drives ready/rvalid/rdata.
// Handshake: a request is accepted on a rising edge where req && ready.
// rvalid then pulses for exactly one cycle, at least one cycle after
// acceptance, and carries rdata for that request.
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a single outstanding memory request.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   imem                 if_stage_if.master instruction-memory bus
//   redirect_valid/_pc   one-cycle branch/jump redirect (target bits [1:0] ignored)
//   id_valid/id_ready    valid/ready handshake towards decode
//   id_inst, id_pc       fetched instruction and its address
//   perf_fetch_cnt       decode transfers (only with IF_STAGE_PERF_EN, else 0)
//   perf_stall_cnt       cycles holding an instruction that decode refused
//                        (only with IF_STAGE_PERF_EN, else 0)
//   state_dbg            current FSM state (00 REQ, 01 WAIT, 10 HOLD, 11 DROP)
//
// Optional feature macro: IF_STAGE_PERF_EN enables the performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  if_stage_if.master   imem,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [31:0]  id_inst,
  output logic [31:0]  id_pc,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10,
    S_DROP = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] redirect_tgt;
  logic        accept;
  logic        take_rsp;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign accept       = imem.req && imem.ready;
  // A response is kept only when no redirect arrives in the same cycle.
  assign take_rsp     = (state == S_WAIT) && imem.rvalid && !redirect_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ:  if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        if (redirect_valid) state_nxt = imem.rvalid ? S_REQ : S_DROP;
        else if (imem.rvalid) state_nxt = S_HOLD;
      end
      S_HOLD: if (redirect_valid || id_ready) state_nxt = S_REQ;
      // The stale response retires DROP even when a further redirect lands
      // in the same cycle; waiting for another rvalid would never end.
      S_DROP: if (imem.rvalid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Output logic; request is held low while reset is asserted.
  always_comb begin
    imem.req  = (state == S_REQ) && !redirect_valid && reset;
    imem.addr = pc;
    state_dbg = state;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      id_valid <= 1'b0;
      id_inst  <= 32'h0000_0013;
      id_pc    <= 32'h0000_0000;
    end else begin
      if (redirect_valid)  pc <= redirect_tgt;
      else if (accept)     pc <= pc + 32'd4;

      if (accept) req_pc <= pc;

      if (take_rsp) begin
        id_valid <= 1'b1;
        id_inst  <= imem.rdata;
        id_pc    <= req_pc;
      end else if ((state == S_HOLD) && (redirect_valid || id_ready)) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (id_valid && id_ready)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

`ifdef IF_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  if_stage_if bus ();
  if_stage_if bus2 ();

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc, perf_fetch_cnt, perf_stall_cnt;
  logic [1:0]  state_dbg;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .state_dbg(state_dbg)
  );

  // Second instance only exercises the top-of-address-space reset value.
  logic        id_valid2;
  logic [31:0] id_inst2, id_pc2, pf2, ps2;
  logic [1:0]  state_dbg2;

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .imem(bus2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid2), .id_ready(1'b1), .id_inst(id_inst2), .id_pc(id_pc2),
    .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2), .state_dbg(state_dbg2)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  // Decode must see consecutive word addresses starting at the reset PC or
  // at the latest redirect target; requests must follow the same rule.
  logic [31:0] exp_pc, exp_req;
  int unsigned cnt_fetch, cnt_stall;
  bit          hold_prev;
  logic [31:0] prev_inst, prev_pc;
  logic [31:0] exp_q[$];   // addresses of requests accepted, awaiting response

  // memory model
  bit          outst;
  int          lat_cnt;
  logic [31:0] resp_addr;
  bit          const_mode;

  // stimulus control
  bit          rnd_mode;
  bit          dir_id_ready;
  bit          dir_redirect;
  logic [31:0] dir_target;
  int          dir_lat;

  // per-cycle samples
  bit          acc_flag;
  logic [31:0] acc_addr;
  bit          smp_valid;
  logic [31:0] smp_inst, smp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_mode) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    exp_pc    = 32'h0;
    exp_req   = 32'h0;
    cnt_fetch = 0;
    cnt_stall = 0;
    hold_prev = 1'b0;
    outst     = 1'b0;
    lat_cnt   = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs on the falling edge, then sample the
  // settled outputs, which describe what the next rising edge will do.
  task automatic cycle();
    bit accept, xfer;
    logic [31:0] tgt;
    @(negedge clk);
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom;
    if (outst) begin
      if (lat_cnt == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = mem_word(resp_addr);
      end else begin
        lat_cnt--;
      end
    end
    if (rnd_mode) begin
      bus.ready      = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFE;
        1:       tgt = 32'h0000_0101;
        default: tgt = $urandom;
      endcase
      redirect_pc = tgt;
    end else begin
      bus.ready      = 1'b1;
      id_ready       = dir_id_ready;
      redirect_valid = dir_redirect;
      redirect_pc    = dir_target;
    end
    dir_redirect = 1'b0;
    #1;
    accept    = bus.req && bus.ready;
    xfer      = id_valid && id_ready;
    acc_flag  = accept;
    acc_addr  = bus.addr;
    smp_valid = id_valid;
    smp_inst  = id_inst;
    smp_pc    = id_pc;

    check("perf_fetch", perf_fetch_cnt, PERF ? cnt_fetch : 32'd0);
    check("perf_stall", perf_stall_cnt, PERF ? cnt_stall : 32'd0);
    if (hold_prev) begin
      check("hold_valid", {31'b0, id_valid}, 32'd1);
      check("hold_inst", id_inst, prev_inst);
      check("hold_pc", id_pc, prev_pc);
    end
    if (id_valid)       check("req_in_hold", {31'b0, bus.req}, 32'd0);
    if (outst)          check("one_outstanding", {31'b0, bus.req}, 32'd0);
    if (redirect_valid) check("req_on_redirect", {31'b0, bus.req}, 32'd0);
    check("addr_eq_pc_seq", bus.addr, bus.req ? exp_req : bus.addr);

    if (xfer) begin
      check("xfer_pc", id_pc, exp_pc);
      check("xfer_inst", id_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      cnt_fetch++;
    end
    if (id_valid && !id_ready) cnt_stall++;
    if (bus.rvalid) begin
      outst = 1'b0;
      void'(exp_q.pop_front());
    end
    if (accept) begin
      check("acc_addr", bus.addr, exp_req);
      outst     = 1'b1;
      resp_addr = bus.addr;
      exp_q.push_back(bus.addr);
      lat_cnt   = rnd_mode ? int'($urandom_range(0, 3)) : dir_lat;
      exp_req   = exp_req + 32'd4;
    end
    if (redirect_valid) begin
      exp_pc  = redirect_pc & 32'hFFFF_FFFC;
      exp_req = redirect_pc & 32'hFFFF_FFFC;
    end
    hold_prev = id_valid && !id_ready && !redirect_valid;
    prev_inst = id_inst;
    prev_pc   = id_pc;
  endtask

  task automatic run_until_accept(output logic [31:0] a, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_flag && n < 50);
    check("accept_timeout", {31'b0, acc_flag}, 32'd1);
    a = acc_addr;
  endtask

  task automatic run_until_valid(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!smp_valid && n < 50);
    check("valid_timeout", {31'b0, smp_valid}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int n;
    bus.ready = 1'b1; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    bus2.ready = 1'b1; bus2.rvalid = 1'b0; bus2.rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    rnd_mode = 1'b0; const_mode = 1'b1; dir_id_ready = 1'b1;
    dir_redirect = 1'b0; dir_target = 32'h0; dir_lat = 0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", {31'b0, bus.req}, 32'd0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_inst", id_inst, 32'h0000_0013);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pfetch", perf_fetch_cnt, 32'h0);
    check("rst_pstall", perf_stall_cnt, 32'h0);
    check("rst2_addr", bus2.addr, 32'hFFFF_FFFC);
    check("rst2_req", {31'b0, bus2.req}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rel2_req", {31'b0, bus2.req}, 32'd1);
    check("rel2_addr", bus2.addr, 32'hFFFF_FFFC);

    // basic sequential fetch, 1-cycle memory latency
    run_until_accept(a, n);
    check("first_req_delay", n, 32'd1);
    check("seq_addr0", a, 32'h0);
    @(posedge clk);
    #1;
    check("wrap2_addr", bus2.addr, 32'h0);
    check("wrap2_req", {31'b0, bus2.req}, 32'd0);
    run_until_valid(n);
    check("latency", n, 32'd2);
    check("seq_inst0", smp_inst, 32'h0050_0093);
    check("seq_pc0", smp_pc, 32'h0);
    run_until_accept(a, n);
    check("seq_addr4", a, 32'h4);
    run_until_valid(n);
    check("seq_pc4", smp_pc, 32'h4);

    // decode stalls for 5 cycles
    dir_id_ready = 1'b0;
    run_until_accept(a, n);
    check("seq_addr8", a, 32'h8);
    run_until_valid(n);
    repeat (4) cycle();
    dir_id_ready = 1'b1;
    cycle();
    check("stall_cnt5", perf_stall_cnt, PERF ? 32'd5 : 32'd0);
    check("stall_pc", smp_pc, 32'h8);

    // redirect during WAIT, response two cycles later
    const_mode = 1'b0;
    dir_lat = 2;
    run_until_accept(a, n);
    dir_redirect = 1'b1; dir_target = 32'h0000_0102;
    cycle();
    run_until_accept(a, n);
    check("redir_wait_addr", a, 32'h0000_0100);
    run_until_valid(n);
    check("redir_wait_pc", smp_pc, 32'h0000_0100);

    // redirect in the same cycle as the response
    dir_lat = 0;
    run_until_accept(a, n);
    dir_redirect = 1'b1; dir_target = 32'h0000_0200;
    cycle();
    check("redir_rv_valid", {31'b0, smp_valid}, 32'd0);
    run_until_accept(a, n);
    check("redir_rv_addr", a, 32'h0000_0200);
    run_until_valid(n);
    check("redir_rv_pc", smp_pc, 32'h0000_0200);

    // redirect in REQ to the last word, then wrap to zero
    dir_redirect = 1'b1; dir_target = 32'hFFFF_FFFF;
    cycle();
    run_until_accept(a, n);
    check("wrap_addr_top", a, 32'hFFFF_FFFC);
    run_until_accept(a, n);
    check("wrap_addr_zero", a, 32'h0);

    // reset during WAIT with the response arriving inside reset
    dir_lat = 3;
    run_until_accept(a, n);
    cycle();
    @(negedge clk);
    reset = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    #1;
    check("rstwait_valid", {31'b0, id_valid}, 32'd0);
    check("rstwait_req", {31'b0, bus.req}, 32'd0);
    @(posedge clk);
    #2;
    bus.rvalid = 1'b0;
    reset = 1'b1;
    model_reset();
    run_until_accept(a, n);
    check("rstwait_first_addr", a, 32'h0);
    check("rstwait_first_delay", n, 32'd1);
    run_until_valid(n);
    check("rstwait_pc", smp_pc, 32'h0);
    check("rstwait_inst", smp_inst, mem_word(32'h0));

    // randomized traffic against the model
    rnd_mode = 1'b1;
    repeat (3000) cycle();

    // drain: let any outstanding response finish
    rnd_mode = 1'b0;
    dir_id_ready = 1'b1;
    repeat (10) cycle();
    check("drain_outstanding", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low (0 = reset asserted).
REQ-004 imem_req  output  1  instruction memory request valid.
REQ-005 imem_addr  output  32  request address, always equal to current PC.
REQ-006 imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-007 imem_rvalid  input  1  read data valid, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect, one-cycle pulse.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 id_valid  output  1  instruction available to decode/immediate generation.
REQ-012 id_ready  input  1  decode accepts when id_valid && id_ready.
REQ-013 id_inst  output  32  fetched instruction word (inst_code of decode).
REQ-014 id_pc  output  32  address of id_inst.
REQ-015 perf_fetch_cnt, perf_stall_cnt  output  32 each  performance counters.

Function
REQ-016 FSM states REQ, WAIT, HOLD, DROP; at most one outstanding memory request.
REQ-017 REQ: imem_req=1 unless redirect_valid this cycle; on acceptance latch req_pc<=pc, pc<=pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), go WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid register id_inst<=imem_rdata, id_pc<=req_pc, id_valid<=1, go HOLD.
REQ-019 HOLD: id_valid, id_inst, id_pc stable until transfer; on transfer clear id_valid next cycle, go REQ.
REQ-020 DROP: imem_req=0; next imem_rvalid discarded (no id_valid), go REQ.
REQ-021 redirect_valid has priority over all events; pc<=redirect_pc with bits [1:0] forced to 00.
REQ-022 Redirect in REQ: imem_req gated to 0 that cycle, stay REQ; next cycle request uses target.
REQ-023 Redirect in WAIT without rvalid: go DROP; with rvalid same cycle: discard data, go REQ.
REQ-024 Redirect in HOLD: id_valid<=0 next cycle regardless of id_ready, go REQ.
REQ-025 Redirect in DROP: update pc, stay DROP.
REQ-026 Minimum latency: acceptance to id_valid = memory latency + 1 cycle; no combinational path imem_rdata->id_inst.

Reset
REQ-027 While reset=0: state REQ, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0, counters 0.
REQ-028 First request asserted first cycle after reset release; reset mid-WAIT abandons outstanding response, any later imem_rvalid before a new acceptance ignored.

Configuration
REQ-029 Macro IF_STAGE_PERF_EN: defined -> perf_fetch_cnt increments per decode transfer, perf_stall_cnt per HOLD cycle with id_ready=0, both wrap at 2^32; undefined -> counters not implemented, outputs tied 0.

Verification
REQ-030 Reset release, RESET_PC=0, imem_ready=1, 1-cycle latency returning 0x00500093 -> imem_addr 0,4,8...; id_inst=0x00500093 id_pc=0 then id_pc=4.
REQ-031 id_ready=0 for 5 cycles in HOLD -> id_inst/id_pc unchanged, no new imem_req; with IF_STAGE_PERF_EN perf_stall_cnt=5.
REQ-032 redirect_valid to 0x0000_0102 during WAIT, rvalid 2 cycles later -> data dropped, next imem_addr=0x0000_0100, id_pc=0x100.
REQ-033 redirect same cycle as imem_rvalid in WAIT -> no id_valid for that data; next request to target.
REQ-034 RESET_PC=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000.
REQ-035 reset asserted during WAIT, imem_rvalid arriving during reset -> id_valid stays 0, first post-reset request to RESET_PC.
